// File: rtl/onchip_memory_pipelined.sv
// Pipelined single-port Avalon-MM on-chip RAM with byte enables, range checking
// and optional per-byte even parity (enable with `define ONCHIP_MEMORY_PARITY_EN).
module onchip_memory_pipelined #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 15,
  parameter int DEPTH      = 32000,
  parameter int RD_LATENCY = 2,
  parameter     INIT_FILE  = "onchip_memory.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                rd_err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  generate
    if ((RD_LATENCY < 1) || (RD_LATENCY > 2) || (DATA_W % 8 != 0) ||
        (DEPTH > (2 ** ADDR_W))) begin : g_bad_cfg
      $error("onchip_memory_pipelined: illegal parameter combination");
    end
    // Initial contents are attached by the vendor RAM initialisation flow.
    if (INIT_FILE == "") begin : g_no_init_file
    end
  endgenerate

  logic w_in_range;
  logic w_wr_accept;
  logic w_rd_accept;
  logic w_rd_mem;
  logic w_par_err;

  assign w_in_range  = ({1'b0, address} < DEPTH_L);
  // Write wins over a simultaneous read, so the read is never accepted then.
  assign w_wr_accept = clken & chipselect & write & w_in_range;
  assign w_rd_accept = clken & chipselect & read & ~write;
  assign w_rd_mem    = w_rd_accept & w_in_range;
  assign waitrequest = ~clken;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) begin
          r_mem[address][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
    if (w_rd_mem) begin
      r_ram_q <= r_mem[address];
    end
  end

`ifdef ONCHIP_MEMORY_PARITY_EN
  logic [NB-1:0] r_par_mem [DEPTH];
  logic [NB-1:0] r_par_q;
  logic [NB-1:0] w_wr_par;
  logic [NB-1:0] w_rd_par;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_par_lane
      assign w_wr_par[gi] = ^writedata[8*gi +: 8];
      assign w_rd_par[gi] = ^r_ram_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) begin
          r_par_mem[address][b] <= w_wr_par[b];
        end
      end
    end
    if (w_rd_mem) begin
      r_par_q <= r_par_mem[address];
    end
  end

  assign w_par_err = |(w_rd_par ^ r_par_q);
`else
  assign w_par_err = 1'b0;
`endif

  logic r_s1_valid;
  logic r_s1_oor;
  logic w_s1_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_oor   <= 1'b0;
    end else if (clken) begin
      r_s1_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_s1_oor <= ~w_in_range;
      end
    end
  end

  assign w_s1_err = r_s1_oor | w_par_err;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] r_readdata;
      logic              r_rdv;
      logic              r_rd_err;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_readdata <= '0;
          r_rdv      <= 1'b0;
          r_rd_err   <= 1'b0;
        end else if (clken) begin
          r_rdv    <= r_s1_valid;
          r_rd_err <= r_s1_valid & w_s1_err;
          if (r_s1_valid) begin
            r_readdata <= r_s1_oor ? '0 : r_ram_q;
          end
        end
      end

      assign readdata      = r_readdata;
      assign readdatavalid = r_rdv;
      assign rd_err        = r_rd_err;
    end else begin : g_lat1
      // RAM output register only loads on in-range reads; this flag masks it
      // to zero after reset or an out-of-range read.
      logic r_data_ok;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_data_ok <= 1'b0;
        end else if (w_rd_accept) begin
          r_data_ok <= w_in_range;
        end
      end

      assign readdata      = r_data_ok ? r_ram_q : '0;
      assign readdatavalid = r_s1_valid;
      assign rd_err        = r_s1_valid & w_s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Scoreboard bench for onchip_memory_pipelined (default build, RD_LATENCY=2).
module tb_onchip_memory_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 15;
  localparam int DEPTH = 32000;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          clken;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;
  logic          rd_err;

  always #5 clk = ~clk;

  onchip_memory_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT),
    .INIT_FILE("onchip_memory.hex")
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .rd_err(rd_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] last_data = '0;
  logic [31:0] model [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (readdatavalid) begin
        if (sb.size() == 0) begin
          check("spurious_rdv", readdatavalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("rd_data", readdata, e.data);
          check("rd_err", rd_err, e.err);
          check("rd_latency", cyc - e.issue, e.lat);
          last_data = e.data;
          $display("read  issue=%0d data=0x%08h err=%0b", e.issue, readdata, rd_err);
        end
      end else begin
        check("idle_err", rd_err, 1'b0);
        check("idle_hold", readdata, last_data);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    if (a < DEPTH) begin
      m = model.exists(a) ? model[a] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m[8*b +: 8] = d[8*b +: 8];
      end
      model[a] = m;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = AW'(a); writedata = d; byteenable = be;
    model_write(a, d, be);
    $display("write addr=%0d data=0x%08h be=0x%0h", a, d, be);
  endtask

  task automatic both(input int a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b1;
    address = AW'(a); writedata = d; byteenable = 4'hF;
    model_write(a, d, 4'hF);
    $display("rd+wr addr=%0d data=0x%08h (read dropped)", a, d);
  endtask

  task automatic rd(input int a, input logic [31:0] d, input logic e, input int lat);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b0; read = 1'b1;
    address = AW'(a);
    sb.push_back('{d, e, cyc, lat});
  endtask

  task automatic rd_model(input int a);
    if (a < DEPTH) rd(a, model.exists(a) ? model[a] : 32'h0, 1'b0, LAT);
    else           rd(a, 32'h0, 1'b1, LAT);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    #1;
    check("reset_rdv", readdatavalid, 1'b0);
    check("reset_err", rd_err, 1'b0);
    check("reset_data", readdata, 32'h0);
    check("reset_waitreq", waitrequest, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Basic write/read and byte-lane merge
    wr(5, 32'hDEADBEEF, 4'hF);
    rd(5, 32'hDEADBEEF, 1'b0, LAT);
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'h5);
    rd(7, 32'h11BB33DD, 1'b0, LAT);
    drain();

    // Back-to-back pipelined reads
    for (int i = 0; i < 4; i++) wr(i, 32'hA5000000 + i * 32'h111, 4'hF);
    for (int i = 0; i < 4; i++) rd(i, 32'hA5000000 + i * 32'h111, 1'b0, LAT);
    drain();

    // Out-of-range accesses
    rd(32000, 32'h0, 1'b1, LAT);
    wr(32001, 32'hFFFFFFFF, 4'hF);
    rd(32001, 32'h0, 1'b1, LAT);
    rd(32767, 32'h0, 1'b1, LAT);
    rd(5, 32'hDEADBEEF, 1'b0, LAT);
    rd(7, 32'h11BB33DD, 1'b0, LAT);
    drain();

    // clken low for 3 clocks with a read in flight
    rd(3, 32'hA5000333, 1'b0, LAT + 3);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; clken = 1'b0;
    #1 check("stall_waitreq", waitrequest, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    clken = 1'b1;
    #1 check("run_waitreq", waitrequest, 1'b0);
    drain();

    // Simultaneous read+write: write wins, read dropped
    wr(9, 32'h0BADF00D, 4'hF);
    both(9, 32'h12345678);
    rd(9, 32'h12345678, 1'b0, LAT);
    drain();

    // Randomised traffic on addresses 16..31 plus occasional out-of-range reads
    for (int i = 16; i < 32; i++) wr(i, $urandom, 4'hF);
    for (int n = 0; n < 80; n++) begin
      int op;
      int a;
      op = $urandom_range(0, 3);
      a  = 16 + $urandom_range(0, 15);
      if (op == 0)      wr(a, $urandom, 4'($urandom));
      else if (op == 1) both(a, $urandom);
      else if ($urandom_range(0, 7) == 0) rd_model(32000 + $urandom_range(0, 767));
      else              rd_model(a);
    end
    drain();

    // Reset asserted while a read is on the output
    rd(5, 32'hDEADBEEF, 1'b0, LAT);
    idle();
    @(posedge clk);
    #2;
    check("inflight_rdv", readdatavalid, 1'b1);
    sb.delete();
    reset_n = 1'b0;
    #1;
    check("midreset_rdv", readdatavalid, 1'b0);
    check("midreset_data", readdata, 32'h0);
    check("midreset_err", rd_err, 1'b0);
    last_data = 32'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(5, 32'hDEADBEEF, 1'b0, LAT);
    rd(7, 32'h11BB33DD, 1'b0, LAT);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/onchip_memory_pipelined.md
ONCHIP_MEMORY_PIPELINED -- requirements
Module: onchip_memory_pipelined

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning word address width.
REQ-003 The block SHALL have parameter DEPTH, default 32000, meaning number of words, at most 2**ADDR_W.
REQ-004 The block SHALL have parameter RD_LATENCY, default 2, meaning read latency in clocks, legal values 1 or 2.
REQ-005 The block SHALL have parameter INIT_FILE, default "onchip_memory.hex", meaning the initial contents file.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-008 The block SHALL have port address, input, ADDR_W bits, the word address.
REQ-009 The block SHALL have port byteenable, input, DATA_W/8 bits, the write byte lanes.
REQ-010 The block SHALL have ports chipselect, read and write, inputs, 1 bit each, Avalon-MM controls.
REQ-011 The block SHALL have port writedata, input, DATA_W bits.
REQ-012 The block SHALL have port clken, input, 1 bit, a global clock enable.
REQ-013 The block SHALL have port readdata, output, DATA_W bits.
REQ-014 The block SHALL have port readdatavalid, output, 1 bit, qualifying readdata.
REQ-015 The block SHALL have port waitrequest, output, 1 bit, driven as the inverse of clken.
REQ-016 The block SHALL have port rd_err, output, 1 bit, valid with readdatavalid.

Function
REQ-017 A write SHALL be accepted on a clock with chipselect=1, write=1 and clken=1, and only byte lanes with byteenable=1 SHALL be updated.
REQ-018 A read SHALL be accepted on a clock with chipselect=1, read=1 and clken=1, and readdatavalid SHALL assert exactly RD_LATENCY clocks later.
REQ-019 Back-to-back reads SHALL be accepted every clock, giving fully pipelined readdatavalid in issue order.
REQ-020 With read=1 and write=1 asserted together, the write SHALL take priority and the read SHALL be dropped (no readdatavalid).
REQ-021 A read in the clock after a write to the same address SHALL return the new data; a read in the same clock as a write is not possible (REQ-020).
REQ-022 An access with address >= DEPTH SHALL be out of range: a write SHALL be discarded, and a read SHALL return readdata=0 with rd_err=1.
REQ-023 With clken=0, all pipeline stages, readdata, readdatavalid and rd_err SHALL hold their values, and no access SHALL be accepted.
REQ-024 When readdatavalid=0, readdata SHALL hold its last valid value and rd_err SHALL be 0.
REQ-025 RD_LATENCY=2 SHALL register the RAM output; RD_LATENCY=1 SHALL drive readdata directly from the RAM output register.

Reset
REQ-026 Asserting reset_n=0 SHALL clear readdatavalid, rd_err, readdata and all pipeline valid flags to 0 asynchronously.
REQ-027 Reset SHALL NOT alter memory contents, and reads already in flight SHALL be discarded.
REQ-028 The first access SHALL be accepted on the first rising edge of clk at which reset_n=1.

Configuration
REQ-029 With ONCHIP_MEMORY_PARITY_EN defined, the block SHALL store one even-parity bit per byte lane, written with that lane.
REQ-030 With ONCHIP_MEMORY_PARITY_EN defined, a parity mismatch on any byte lane of a read SHALL set rd_err=1 alongside readdatavalid, and the data SHALL be returned unmodified.
REQ-031 Without ONCHIP_MEMORY_PARITY_EN, no parity storage SHALL exist and rd_err SHALL signal only out-of-range reads.

Verification
REQ-032 Bench scenario: write 0xDEADBEEF to address 5 with byteenable=0xF, then read address 5 -> readdata=0xDEADBEEF and readdatavalid exactly 2 clocks after the read, rd_err=0.
REQ-033 Bench scenario: write 0x11223344 to address 7 with byteenable=0xF, then write 0xAABBCCDD to address 7 with byteenable=0x5, then read address 7 -> 0x11BB33DD.
REQ-034 Bench scenario: reads to addresses 0,1,2,3 on consecutive clocks -> four consecutive readdatavalid pulses, with data in the same order.
REQ-035 Bench scenario: read address 32000 -> readdata=0 and rd_err=1; write to address 32001 followed by a read -> no memory change.
REQ-036 Bench scenario: hold clken=0 for 3 clocks with a read in flight -> readdatavalid is delayed by exactly 3 clocks and data is intact.
REQ-037 Bench scenario: assert reset_n=0 mid-read -> readdatavalid=0 immediately, and a subsequent read of previously written data returns it unchanged.
